// File: rtl/usart_tx_arbiter.sv
// usart_tx_arbiter: packet-granular round-robin sharing of one usart TX FIFO write port.
// Optional stalled-lock revocation with timeout_evt when USART_TX_ARB_TIMEOUT_EN is defined.
module usart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic [DATA_W-1:0]       tx_data_in,
    output logic                    tx_write_en,
    input  logic                    tx_full
`ifdef USART_TX_ARB_TIMEOUT_EN
    ,
    output logic                    timeout_evt
`endif
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   owner, owner_nx, ptr, ptr_nx, sel, idx;
    logic [N_REQ-1:0] owner_oh;
    logic            locked, hs, done, to;

    assign owner_oh = N_REQ'(1) << owner;
    assign locked   = (state == LOCKED) && !rst;
    assign hs       = locked && req_valid[owner] && !tx_full;
    assign done     = hs && req_last[owner];

`ifdef USART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    assign to          = locked && (cnt == CW'(TIMEOUT));
    assign timeout_evt = to;
    // Only owner silence counts; tx_full stalls with valid held are not abandonment.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || hs)
            cnt <= '0;
        else if (!req_valid[owner])
            cnt <= cnt + 1'b1;
    end
`else
    assign to = 1'b0;
`endif

    // Lowest offset from ptr wins, so scan offsets from high to low.
    always_comb begin
        sel = '0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (req_valid[idx])
                sel = idx;
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        ptr_nx   = ptr;
        if (state == IDLE) begin
            if (|req_valid) begin
                state_nx = LOCKED;
                owner_nx = sel;
            end
        end else if (done || to) begin
            state_nx = IDLE;
            ptr_nx   = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            ptr   <= ptr_nx;
        end
    end

    assign busy        = (state == LOCKED);
    assign grant       = busy ? owner_oh : '0;
    assign req_ready   = (locked && !tx_full) ? owner_oh : '0;
    assign tx_write_en = hs;
    assign tx_data_in  = locked ? req_data[int'(owner)*DATA_W +: DATA_W] : '0;
endmodule

// File: tb/tb_usart_tx_arbiter.sv
// tb_usart_tx_arbiter: directed self-checking bench for usart_tx_arbiter (N_REQ=4, DATA_W=8).
module tb_usart_tx_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_last = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0] req_ready, grant;
    logic         busy, tx_write_en;
    logic         tx_full = 1'b0;
    logic [W-1:0] tx_data_in;
`ifdef USART_TX_ARB_TIMEOUT_EN
    logic         timeout_evt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [17:0]  obs, ex;
    logic [N-1:0] mask, bc;

    assign obs = {grant, req_ready, busy, tx_write_en, tx_data_in};

    usart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant), .busy(busy),
        .tx_data_in(tx_data_in), .tx_write_en(tx_write_en), .tx_full(tx_full)
`ifdef USART_TX_ARB_TIMEOUT_EN
        , .timeout_evt(timeout_evt)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = mask[i];
            req_data[i*W +: W] = bc[i] ? 8'h99 : 8'hF0;
            req_last[i]        = bc[i];
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 4'b1111;
        req_data = {4{8'h55}};
        cyc; cyc;
        #1 ex = '0;
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL reset_held: got %h want %h", obs, ex); end
        cyc;
        #1 ex = '0;
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL reset_held2: got %h want %h", obs, ex); end
        rst = 1'b0;
        req_valid = '0;
        #1 ex = '0;
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL reset_idle: got %h want %h", obs, ex); end
        cyc;
    endtask

    task automatic test_single;
        req_valid = 4'b0010;
        req_data[8 +: 8] = 8'hA5;
        req_last = '0;
        #1 ex = '0;
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL single_idle: got %h want %h", obs, ex); end
        cyc;
        #1 ex = {4'b0010, 4'b0010, 1'b1, 1'b1, 8'hA5};
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL single_b0: got %h want %h", obs, ex); end
        cyc;
        req_data[8 +: 8] = 8'h3C;
        req_last = 4'b0010;
        #1 ex = {4'b0010, 4'b0010, 1'b1, 1'b1, 8'h3C};
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL single_b1: got %h want %h", obs, ex); end
        cyc;
        req_valid = '0;
        req_last = '0;
        #1 ex = '0;
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL single_end: got %h want %h", obs, ex); end
        cyc;
        #1 ex = '0;
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL single_stay: got %h want %h", obs, ex); end
    endtask

    task automatic test_round_robin;
        logic [1:0] seq [3];
        logic [N-1:0] oh;
        seq = '{2'd0, 2'd2, 2'd3};
        rst = 1'b1;
        cyc;
        rst = 1'b0;
        mask = 4'b1101;
        bc = '0;
        drive;
        for (int p = 0; p < 6; p++) begin
            oh = 4'b0001 << seq[p % 3];
            #1 ex = '0;
            n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL rr_idle p%0d: got %h want %h", p, obs, ex); end
            cyc; drive;
            #1 ex = {oh, oh, 1'b1, 1'b1, 8'hF0};
            n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL rr_b0 p%0d: got %h want %h", p, obs, ex); end
            bc[seq[p % 3]] = 1'b1;
            cyc; drive;
            #1 ex = {oh, oh, 1'b1, 1'b1, 8'h99};
            n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL rr_b1 p%0d: got %h want %h", p, obs, ex); end
            bc[seq[p % 3]] = 1'b0;
            cyc; drive;
        end
        req_valid = '0;
        req_last = '0;
    endtask

    task automatic test_backpressure;
        req_valid = 4'b0001;
        req_data[0 +: 8] = 8'hF0;
        req_last = '0;
        cyc;
        #1 ex = {4'b0001, 4'b0001, 1'b1, 1'b1, 8'hF0};
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL bp_b0: got %h want %h", obs, ex); end
        cyc;
        req_data[0 +: 8] = 8'h99;
        req_last = 4'b0001;
        tx_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 ex = {4'b0001, 4'b0000, 1'b1, 1'b0, 8'h99};
            n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL bp_full k%0d: got %h want %h", k, obs, ex); end
            cyc;
        end
        tx_full = 1'b0;
        #1 ex = {4'b0001, 4'b0001, 1'b1, 1'b1, 8'h99};
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL bp_release: got %h want %h", obs, ex); end
        cyc;
        req_valid = '0;
        req_last = '0;
        #1 ex = '0;
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL bp_after: got %h want %h", obs, ex); end
        cyc;
    endtask

    task automatic test_gaps;
        req_valid = 4'b0001;
        req_data[0 +: 8] = 8'hF0;
        req_last = '0;
        cyc;
        #1 ex = {4'b0001, 4'b0001, 1'b1, 1'b1, 8'hF0};
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL gap_b0: got %h want %h", obs, ex); end
        cyc;
        req_valid = 4'b0010;
        req_data[8 +: 8] = 8'h11;
        req_last = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            #1 ex = {4'b0001, 4'b0001, 1'b1, 1'b0, 8'hF0};
            n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL gap_hold k%0d: got %h want %h", k, obs, ex); end
            cyc;
        end
        req_valid = 4'b0011;
        req_data[0 +: 8] = 8'h99;
        req_last = 4'b0011;
        #1 ex = {4'b0001, 4'b0001, 1'b1, 1'b1, 8'h99};
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL gap_last: got %h want %h", obs, ex); end
        cyc;
        req_valid = 4'b0010;
        req_last = 4'b0010;
        #1 ex = '0;
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL gap_bubble: got %h want %h", obs, ex); end
        cyc;
        #1 ex = {4'b0010, 4'b0010, 1'b1, 1'b1, 8'h11};
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL gap_next: got %h want %h", obs, ex); end
        cyc;
        req_valid = '0;
        req_last = '0;
        #1 ex = '0;
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL gap_end: got %h want %h", obs, ex); end
        cyc;
    endtask

    task automatic test_reset_mid;
        req_valid = 4'b0100;
        req_data[16 +: 8] = 8'hF0;
        req_last = '0;
        cyc;
        #1 ex = {4'b0100, 4'b0100, 1'b1, 1'b1, 8'hF0};
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL rstmid_b0: got %h want %h", obs, ex); end
        cyc;
        req_data[16 +: 8] = 8'h99;
        rst = 1'b1;
        #1 ex = {4'b0100, 4'b0000, 1'b1, 1'b0, 8'h00};
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL rstmid_during: got %h want %h", obs, ex); end
        cyc;
        rst = 1'b0;
        req_valid = 4'b0101;
        req_data[0 +: 8] = 8'hF0;
        #1 ex = '0;
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL rstmid_after: got %h want %h", obs, ex); end
        cyc;
        #1 ex = {4'b0001, 4'b0001, 1'b1, 1'b1, 8'hF0};
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL rstmid_ptr0: got %h want %h", obs, ex); end
        cyc;
        req_valid = 4'b0001;
        req_data[0 +: 8] = 8'h99;
        req_last = 4'b0001;
        #1 ex = {4'b0001, 4'b0001, 1'b1, 1'b1, 8'h99};
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL rstmid_last: got %h want %h", obs, ex); end
        cyc;
        req_valid = '0;
        req_last = '0;
        #1 ex = '0;
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL rstmid_end: got %h want %h", obs, ex); end
        cyc;
    endtask

`ifdef USART_TX_ARB_TIMEOUT_EN
    task automatic test_timeout;
        rst = 1'b1;
        cyc;
        rst = 1'b0;
        req_valid = 4'b1000;
        req_data[24 +: 8] = 8'hF0;
        req_last = '0;
        cyc;
        #1 ex = {4'b1000, 4'b1000, 1'b1, 1'b1, 8'hF0};
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL to_b0: got %h want %h", obs, ex); end
        cyc;
        req_valid = 4'b0001;
        req_data[0 +: 8] = 8'h11;
        req_last = 4'b0001;
        for (int k = 1; k <= 64; k++) begin
            #1;
            n_cmp++; if ({timeout_evt, grant} !== 5'b01000) begin n_err++; $display("FAIL to_wait k%0d: got %b want %b", k, {timeout_evt, grant}, 5'b01000); end
            cyc;
        end
        #1;
        n_cmp++; if ({timeout_evt, grant} !== 5'b11000) begin n_err++; $display("FAIL to_evt: got %b want %b", {timeout_evt, grant}, 5'b11000); end
        cyc;
        #1 ex = '0;
        n_cmp++; if ({obs, timeout_evt} !== {ex, 1'b0}) begin n_err++; $display("FAIL to_bubble: got %h want %h", {obs, timeout_evt}, {ex, 1'b0}); end
        cyc;
        #1 ex = {4'b0001, 4'b0001, 1'b1, 1'b1, 8'h11};
        n_cmp++; if (obs !== ex) begin n_err++; $display("FAIL to_next: got %h want %h", obs, ex); end
        cyc;
        req_valid = '0;
        req_last = '0;
        cyc;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_gaps;
        test_reset_mid;
`ifdef USART_TX_ARB_TIMEOUT_EN
        test_timeout;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/usart_tx_arbiter.md
Name: usart_tx_arbiter

Overview:
- Shares the single `usart` TX FIFO write port (`tx_data_in` / `tx_write_en` / `tx_full`) among N_REQ byte-stream requesters.
- Arbitration is round-robin at packet granularity. A granted requester keeps the port until it delivers a byte flagged `req_last`, so packets from different requesters never interleave on the serial line.
- The block sits between on-chip clients (debug console, sensor logger, etc.) and the `usart` instance.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- DATA_W, 8: byte width; must match the usart `tx_data_in` width.
- TIMEOUT, 64: idle cycles before a stalled lock is revoked. Used only with the optional feature.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  N_REQ  requester i has a byte available.
- req_data  in  N_REQ*DATA_W  packed bytes; requester i at bits [i*DATA_W +: DATA_W].
- req_last  in  N_REQ  requester i's current byte is the last of its packet.
- req_ready  out  N_REQ  byte of requester i accepted this cycle when req_valid[i] & req_ready[i].
- grant  out  N_REQ  one-hot current owner; all-zero when idle.
- busy  out  1  a lock is held (state LOCKED).
- tx_data_in  out  DATA_W  to usart `tx_data_in`.
- tx_write_en  out  1  to usart `tx_write_en`.
- tx_full  in  1  from usart `tx_full`.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Clears state to IDLE, grant=0, busy=0, and the round-robin pointer ptr to 0.
  - While rst=1: req_ready=0, tx_write_en=0, tx_data_in=0.
- State IDLE:
  - req_ready=0, tx_write_en=0, tx_data_in=0.
  - If any req_valid bit is set, select the first set index scanning ptr, ptr+1, ... modulo N_REQ.
  - Next cycle: grant=onehot(sel), busy=1, state LOCKED.
  - If no req_valid bit is set, stay in IDLE.
- State LOCKED, owner g:
  - req_ready[g] = ~tx_full; all other req_ready bits are 0. This is combinational from registered state and tx_full.
  - tx_write_en = req_valid[g] & ~tx_full, combinational, so the FIFO write happens in the same cycle as the handshake (zero latency).
  - tx_data_in = req_data slice g while in LOCKED, regardless of tx_write_en.
  - Handshake with req_last[g]=1: next cycle returns to IDLE, grant=0, busy=0, ptr=(g+1) mod N_REQ.
  - Handshake with req_last[g]=0: stay LOCKED.
- Bubble rule: at least one IDLE cycle separates consecutive packets, including back-to-back packets from the same requester.
- Gaps: req_valid[g] may drop mid-packet. The lock is held with no writes, and other requesters wait.
- tx_full=1: no handshake and no write. Owner data must stay stable until accepted; the arbiter buffers nothing.
- req_last on a non-owner, or a valid from a non-owner: ignored.
- Mid-packet reset: the lock is dropped immediately. The partial packet already in the FIFO is not recalled, and after reset arbitration restarts from ptr=0.
- Invariants:
  - grant is always one-hot or zero.
  - busy = |grant.
  - tx_write_en implies exactly one req_valid & req_ready handshake in the same cycle.

Optional Feature:
- Macro: USART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) clears on grant and on every handshake.
  - It increments each LOCKED cycle with req_valid[g]=0. Cycles stalled by tx_full while valid=1 do not count.
  - When the count reaches TIMEOUT, the lock is revoked next cycle exactly as if last had been sent (IDLE, ptr=g+1).
  - A one-cycle pulse is raised on extra output timeout_evt (1 bit).
- Not defined: no counter and no timeout_evt port. An abandoned lock persists until a req_last handshake or reset.

Test Plan:
- Basic single packet:
  - Stimulus: after reset, requester 1 sends 0xA5, 0x3C (last) with tx_full=0.
  - Expected: grant=0010 one cycle after valid; tx_write_en high for 2 cycles carrying A5, then 3C; IDLE afterward.
- Round-robin fairness:
  - Stimulus: requesters 0, 2 and 3 continuously send 2-byte packets (0xF0, 0x99).
  - Expected: grant order 0, 2, 3, 0, ...; one IDLE bubble between packets; no interleaving.
- Backpressure:
  - Stimulus: tx_full=1 for 5 cycles mid-packet while the owner holds 0x99.
  - Expected: req_ready=0 and tx_write_en=0 throughout; exactly one write of 0x99 when tx_full falls.
- Packet gaps and contention:
  - Stimulus: owner 0 drops valid for 10 cycles mid-packet while requester 1 is valid.
  - Expected: grant stays 0001 and no writes occur; requester 1 is granted only after owner 0's last byte.
- Reset mid-packet:
  - Stimulus: rst=1 for 1 cycle during owner 2's second byte.
  - Expected: grant=0, busy=0, tx_write_en=0 the following cycle; the next arbitration starts from requester 0.
- Timeout (USART_TX_ARB_TIMEOUT_EN, TIMEOUT=64):
  - Stimulus: owner 3 stops after 1 byte with no last.
  - Expected: timeout_evt pulses after 64 idle cycles; grant moves to waiting requester 0.
